// File: rtl/rp_asg_pkg.sv
// Shared types and helpers for the ASG channel: FSM state encoding, output
// source select, output pipeline latency and signed saturation.
package rp_asg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DONE,
    ST_RUN,
    ST_LAST,
    ST_DLY
  } asg_state_e;

  typedef enum logic [1:0] {
    SEL_FIRST,
    SEL_LAST,
    SEL_TABLE
  } out_sel_e;

  // Clocks from a state/pointer change to the matching dac_o value.
  localparam int unsigned LAT = 6;

  // Clamp x to the w-bit two's complement range.
  function automatic logic signed [63:0] sat(input logic signed [63:0] x,
                                             input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/rp_asg_ch_interp_if.sv
// Waveform table write port shared by the register bank (master) and the
// channel (slave).
interface rp_asg_ch_interp_if #(
  parameter int DW  = 14,
  parameter int RSZ = 14
);
  logic           we;
  logic [RSZ-1:0] addr;
  logic [DW-1:0]  wdata;

  modport master (output we, addr, wdata);
  modport slave  (input  we, addr, wdata);
endinterface

// File: rtl/rp_asg_interp.sv
// Two-stage linear interpolator: y = s0 + ((s1 - s0) * w >>> IW).
// The difference is kept DW+1 bits wide so it can never overflow.
module rp_asg_interp #(
  parameter int DW = 14,
  parameter int IW = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic signed [DW-1:0] s0_i,
  input  logic signed [DW-1:0] s1_i,
  input  logic        [IW-1:0] w_i,
  output logic signed [DW-1:0] y_o
);

  logic signed [DW:0]      diff_q;
  logic signed [DW-1:0]    s0_q;
  logic        [IW-1:0]    w_q;
  logic signed [DW+IW+1:0] prod;
  logic signed [DW-1:0]    y_q;

  always_comb begin
    prod = (DW+IW+2)'(diff_q) * (DW+IW+2)'($signed({1'b0, w_q}));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      diff_q <= '0;
      s0_q   <= '0;
      w_q    <= '0;
      y_q    <= '0;
    end else begin
      diff_q <= (DW+1)'(s1_i) - (DW+1)'(s0_i);
      s0_q   <= s0_i;
      w_q    <= w_i;
      y_q    <= s0_q + DW'(prod >>> IW);
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/rp_asg_ch_interp.sv
// ASG channel: table playback with fractional pointer, optional interpolation,
// burst sequencing and scale/offset into one DAC lane.
//   state | meaning
//   IDLE  | waiting for trigger, output set_first_i
//   RUN   | stepping through the table, output table samples
//   LAST  | holding set_last_i for set_last_len_i clocks after a burst
//   DLY   | repetition delay, output set_last_i
//   DONE  | burst sequence finished, output set_last_i, re-triggerable
module rp_asg_ch_interp
  import rp_asg_pkg::*;
#(
  parameter int DW  = 14,
  parameter int RSZ = 14,
  parameter int FW  = 32,
  parameter int IW  = 16
) (
  input  logic                  dac_clk_i,
  input  logic                  dac_rst_i,
  input  logic                  trig_i,
  rp_asg_ch_interp_if.slave     buf_if,
  input  logic [RSZ:0]          set_size_i,
  input  logic [RSZ+FW-1:0]     set_ofs_i,
  input  logic [RSZ+FW-1:0]     set_step_i,
  input  logic [15:0]           set_ncyc_i,
  input  logic [15:0]           set_rnum_i,
  input  logic [31:0]           set_rdly_i,
  input  logic signed [DW-1:0]  set_last_i,
  input  logic [31:0]           set_last_len_i,
  input  logic signed [DW-1:0]  set_first_i,
  input  logic [DW-1:0]         set_amp_i,
  input  logic signed [DW-1:0]  set_dc_i,
  input  logic                  set_interp_i,
  input  logic                  set_zero_i,
  input  logic                  set_rst_i,
  output logic signed [DW-1:0]  dac_o,
  output logic                  trig_done_o,
  output logic                  busy_o,
  output logic [RSZ-1:0]        rpnt_o
);

  localparam int SEL_DLY = LAT - 3;

  asg_state_e          state_q, state_d;
  logic [RSZ+FW-1:0]   pnt_q, pnt_d, pnt_run;
  logic [15:0]         cyc_q, cyc_d;
  logic [15:0]         rep_q, rep_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                trig_done_q, trig_done_d;
  logic [RSZ-1:0]      rpnt_q;
  logic [RSZ+FW:0]     sum_w, lim_w;
  logic                wrap;
  logic                go_dly, rep_end;

  logic [DW-1:0]        ram0_q [2**RSZ];
  logic [DW-1:0]        ram1_q [2**RSZ];
  logic [RSZ-1:0]       idx, idx1;
  logic [RSZ:0]         idx_inc;
  logic signed [DW-1:0] s0_q, s1_q, y_interp;
  logic [IW-1:0]        w_q;
  out_sel_e             sel_d;
  out_sel_e             sel_q [SEL_DLY];
  logic signed [DW-1:0] ymux_q, ymux_d;
  logic signed [2*DW:0] scl_prod;
  logic signed [DW+1:0] scl_q;
  logic signed [DW+2:0] ofs_sum;
  logic signed [DW-1:0] dac_q;

  // Pointer advance with a single wrap subtraction at size<<FW.
  always_comb begin
    sum_w   = {1'b0, pnt_q} + {1'b0, set_step_i};
    lim_w   = {set_size_i, {FW{1'b0}}};
    wrap    = (sum_w >= lim_w);
    pnt_run = (RSZ+FW)'(wrap ? sum_w - lim_w : sum_w);
  end

  always_comb begin
    state_d     = state_q;
    pnt_d       = pnt_q;
    cyc_d       = cyc_q;
    rep_d       = rep_q;
    cnt_d       = cnt_q;
    trig_done_d = 1'b0;
    go_dly      = 1'b0;
    rep_end     = 1'b0;
    if (set_rst_i) begin
      state_d = ST_IDLE;
      pnt_d   = set_ofs_i;
      cyc_d   = '0;
      rep_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (trig_i) begin
            state_d     = ST_RUN;
            pnt_d       = set_ofs_i;
            cyc_d       = set_ncyc_i;
            rep_d       = set_rnum_i;
            trig_done_d = 1'b1;
          end
        end
        ST_RUN: begin
          pnt_d = pnt_run;
          if (wrap && (set_ncyc_i != 16'd0)) begin
            if (cyc_q == 16'd1) begin
              if (set_last_len_i != 32'd0) begin
                state_d = ST_LAST;
                cnt_d   = set_last_len_i;
              end else begin
                go_dly = 1'b1;
              end
            end else begin
              cyc_d = cyc_q - 16'd1;
            end
          end
        end
        ST_LAST: begin
          if (cnt_q <= 32'd1) go_dly = 1'b1;
          else                cnt_d  = cnt_q - 32'd1;
        end
        ST_DLY: begin
          if (cnt_q <= 32'd1) rep_end = 1'b1;
          else                cnt_d   = cnt_q - 32'd1;
        end
        default: state_d = ST_IDLE;
      endcase
      if (go_dly) begin
        if (set_rdly_i != 32'd0) begin
          state_d = ST_DLY;
          cnt_d   = set_rdly_i;
        end else begin
          rep_end = 1'b1;
        end
      end
      // rnum of all-ones repeats forever, so its counter is never consumed.
      if (rep_end) begin
        if (rep_q != 16'd0) begin
          state_d = ST_RUN;
          pnt_d   = set_ofs_i;
          cyc_d   = set_ncyc_i;
          if (set_rnum_i != 16'hFFFF) rep_d = rep_q - 16'd1;
        end else begin
          state_d = ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q     <= ST_IDLE;
      pnt_q       <= set_ofs_i;
      cyc_q       <= '0;
      rep_q       <= '0;
      cnt_q       <= '0;
      trig_done_q <= 1'b0;
      rpnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      pnt_q       <= pnt_d;
      cyc_q       <= cyc_d;
      rep_q       <= rep_d;
      cnt_q       <= cnt_d;
      trig_done_q <= trig_done_d;
      rpnt_q      <= pnt_d[RSZ+FW-1:FW];
    end
  end

  // Two table copies so the current and next samples read in one clock.
  always_ff @(posedge dac_clk_i) begin
    if (buf_if.we) begin
      ram0_q[buf_if.addr] <= buf_if.wdata;
      ram1_q[buf_if.addr] <= buf_if.wdata;
    end
  end

  always_comb begin
    idx     = pnt_q[RSZ+FW-1:FW];
    idx_inc = {1'b0, idx} + (RSZ+1)'(1);
    idx1    = (idx_inc == set_size_i) ? '0 : idx_inc[RSZ-1:0];
    case (state_q)
      ST_IDLE: sel_d = SEL_FIRST;
      ST_RUN:  sel_d = SEL_TABLE;
      default: sel_d = SEL_LAST;
    endcase
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      s0_q <= '0;
      s1_q <= '0;
      w_q  <= '0;
      for (int k = 0; k < SEL_DLY; k++) sel_q[k] <= SEL_FIRST;
    end else begin
      s0_q     <= ram0_q[idx];
      s1_q     <= ram1_q[idx1];
      w_q      <= set_interp_i ? pnt_q[FW-1 -: IW] : '0;
      sel_q[0] <= sel_d;
      for (int k = 1; k < SEL_DLY; k++) sel_q[k] <= sel_q[k-1];
    end
  end

  rp_asg_interp #(.DW(DW), .IW(IW)) u_interp (
    .clk_i (dac_clk_i),
    .rst_i (dac_rst_i),
    .s0_i  (s0_q),
    .s1_i  (s1_q),
    .w_i   (w_q),
    .y_o   (y_interp)
  );

  always_comb begin
    ymux_d = set_last_i;
    if (set_zero_i) begin
      ymux_d = '0;
    end else begin
      case (sel_q[SEL_DLY-1])
        SEL_TABLE: ymux_d = y_interp;
        SEL_FIRST: ymux_d = set_first_i;
        default:   ymux_d = set_last_i;
      endcase
    end
    scl_prod = (2*DW+1)'(ymux_q) * (2*DW+1)'($signed({1'b0, set_amp_i}));
    ofs_sum  = (DW+3)'(scl_q) + (DW+3)'(set_dc_i);
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      ymux_q <= '0;
      scl_q  <= '0;
      dac_q  <= '0;
    end else begin
      ymux_q <= ymux_d;
      scl_q  <= (DW+2)'(scl_prod >>> (DW-1));
      dac_q  <= DW'(sat(64'(ofs_sum), DW));
    end
  end

  assign dac_o       = dac_q;
  assign trig_done_o = trig_done_q;
  assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign rpnt_o      = rpnt_q;

endmodule

// File: tb/tb_rp_asg_ch_interp.sv
// Directed bench for rp_asg_ch_interp with DW=14, RSZ=4, FW=8, IW=8 and
// hand-computed expected outputs.
module tb_rp_asg_ch_interp;
  import rp_asg_pkg::*;

  localparam int DW  = 14;
  localparam int RSZ = 4;
  localparam int FW  = 8;
  localparam int IW  = 8;

  logic                 clk;
  logic                 rst;
  logic                 trig_i;
  logic [RSZ:0]         set_size_i;
  logic [RSZ+FW-1:0]    set_ofs_i;
  logic [RSZ+FW-1:0]    set_step_i;
  logic [15:0]          set_ncyc_i;
  logic [15:0]          set_rnum_i;
  logic [31:0]          set_rdly_i;
  logic signed [DW-1:0] set_last_i;
  logic [31:0]          set_last_len_i;
  logic signed [DW-1:0] set_first_i;
  logic [DW-1:0]        set_amp_i;
  logic signed [DW-1:0] set_dc_i;
  logic                 set_interp_i;
  logic                 set_zero_i;
  logic                 set_rst_i;
  logic signed [DW-1:0] dac_o;
  logic                 trig_done_o;
  logic                 busy_o;
  logic [RSZ-1:0]       rpnt_o;

  int n_chk;
  int n_pass;

  int   dac_log  [128];
  int   rpnt_log [128];
  logic busy_log [128];
  logic td_log   [128];

  localparam int FIRST = 123;
  localparam int LASTV = -77;

  rp_asg_ch_interp_if #(.DW(DW), .RSZ(RSZ)) buf_if ();

  rp_asg_ch_interp #(.DW(DW), .RSZ(RSZ), .FW(FW), .IW(IW)) dut (
    .dac_clk_i      (clk),
    .dac_rst_i      (rst),
    .trig_i         (trig_i),
    .buf_if         (buf_if.slave),
    .set_size_i     (set_size_i),
    .set_ofs_i      (set_ofs_i),
    .set_step_i     (set_step_i),
    .set_ncyc_i     (set_ncyc_i),
    .set_rnum_i     (set_rnum_i),
    .set_rdly_i     (set_rdly_i),
    .set_last_i     (set_last_i),
    .set_last_len_i (set_last_len_i),
    .set_first_i    (set_first_i),
    .set_amp_i      (set_amp_i),
    .set_dc_i       (set_dc_i),
    .set_interp_i   (set_interp_i),
    .set_zero_i     (set_zero_i),
    .set_rst_i      (set_rst_i),
    .dac_o          (dac_o),
    .trig_done_o    (trig_done_o),
    .busy_o         (busy_o),
    .rpnt_o         (rpnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic buf_write(input int a, input int d);
    buf_if.we    = 1'b1;
    buf_if.addr  = RSZ'(a);
    buf_if.wdata = DW'(d);
    tick();
    buf_if.we    = 1'b0;
  endtask

  task automatic log_at(input int t);
    dac_log[t]  = int'(dac_o);
    rpnt_log[t] = int'(rpnt_o);
    busy_log[t] = busy_o;
    td_log[t]   = trig_done_o;
  endtask

  // Entry t holds outputs just after the t-th edge, edge 0 accepting the trigger.
  task automatic burst(input int n);
    trig_i = 1'b1;
    tick();
    trig_i = 1'b0;
    log_at(0);
    for (int t = 1; t < n; t++) begin
      tick();
      log_at(t);
    end
  endtask

  initial begin
    int exp;
    int td_cnt;
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    trig_i = 1'b0;
    buf_if.we = 1'b0;
    buf_if.addr = '0;
    buf_if.wdata = '0;
    set_size_i = 5'd16;
    set_ofs_i = '0;
    set_step_i = 12'h100;
    set_ncyc_i = 16'd2;
    set_rnum_i = 16'd0;
    set_rdly_i = 32'd0;
    set_last_i = DW'(LASTV);
    set_last_len_i = 32'd0;
    set_first_i = DW'(FIRST);
    set_amp_i = 14'h2000;
    set_dc_i = '0;
    set_interp_i = 1'b1;
    set_zero_i = 1'b0;
    set_rst_i = 1'b0;

    repeat (3) tick();
    check_val("rst_dac", int'(dac_o), 0);
    check_val("rst_busy", int'(busy_o), 0);
    check_val("rst_trig_done", int'(trig_done_o), 0);
    check_val("rst_rpnt", int'(rpnt_o), 0);
    rst = 1'b0;

    for (int k = 0; k < 16; k++) buf_write(k, k * 100);
    repeat (LAT + 1) tick();
    check_val("idle_first", int'(dac_o), FIRST);

    // Plain ramp, two table cycles, straight to DONE.
    burst(40);
    check_val("ramp_td0", int'(td_log[0]), 1);
    check_val("ramp_td1", int'(td_log[1]), 0);
    check_val("ramp_busy0", int'(busy_log[0]), 1);
    check_val("ramp_rpnt0", rpnt_log[0], 0);
    check_val("ramp_rpnt5", rpnt_log[5], 5);
    for (int j = 0; j < 32; j++)
      check_val($sformatf("ramp[%0d]", j), dac_log[LAT + j], (j % 16) * 100);
    check_val("ramp_busy31", int'(busy_log[31]), 1);
    check_val("ramp_busy32", int'(busy_log[32]), 0);
    check_val("ramp_last", dac_log[LAT + 32], LASTV);

    // Half-sample step with interpolation; index 15 blends toward buf[0].
    set_step_i = 12'h080;
    set_ncyc_i = 16'd1;
    burst(40);
    for (int j = 0; j < 32; j++) begin
      exp = (j == 31) ? 750 : 50 * j;
      check_val($sformatf("interp[%0d]", j), dac_log[LAT + j], exp);
    end
    check_val("interp_busy32", int'(busy_log[32]), 0);
    check_val("interp_last", dac_log[LAT + 32], LASTV);

    set_interp_i = 1'b0;
    burst(40);
    check_val("nointerp0", dac_log[LAT + 0], 0);
    check_val("nointerp1", dac_log[LAT + 1], 0);
    check_val("nointerp2", dac_log[LAT + 2], 100);
    check_val("nointerp3", dac_log[LAT + 3], 100);
    set_interp_i = 1'b1;

    // One repetition with last-hold and delay.
    set_step_i = 12'h100;
    set_rnum_i = 16'd1;
    set_rdly_i = 32'd10;
    set_last_len_i = 32'd5;
    burst(70);
    for (int j = 0; j < 16; j++)
      check_val($sformatf("rep_a[%0d]", j), dac_log[LAT + j], j * 100);
    check_val("rep_last_start", dac_log[22], LASTV);
    check_val("rep_dly_end", dac_log[36], LASTV);
    for (int j = 0; j < 16; j++)
      check_val($sformatf("rep_b[%0d]", j), dac_log[37 + j], j * 100);
    check_val("rep_busy61", int'(busy_log[61]), 1);
    check_val("rep_busy62", int'(busy_log[62]), 0);
    check_val("rep_final", dac_log[69], LASTV);
    td_cnt = 0;
    for (int t = 0; t < 70; t++) if (td_log[t]) td_cnt++;
    check_val("rep_td_count", td_cnt, 1);

    // Continuous single-sample table: saturation, retrigger, zero force.
    set_rnum_i = 16'd0;
    set_rdly_i = 32'd0;
    set_last_len_i = 32'd0;
    set_ncyc_i = 16'd0;
    set_size_i = 5'd1;
    buf_write(0, 14'h1FFF);
    set_amp_i = 14'h3FFF;
    set_dc_i = 14'h1000;
    burst(3);
    check_val("cont_td", int'(td_log[0]), 1);
    trig_i = 1'b1;
    tick();
    trig_i = 1'b0;
    check_val("cont_retrig_td", int'(trig_done_o), 0);
    check_val("cont_retrig_busy", int'(busy_o), 1);
    repeat (LAT + 1) tick();
    check_val("sat_pos", int'(dac_o), 8191);
    buf_write(0, 14'h2000);
    set_dc_i = DW'(-1);
    repeat (LAT + 2) tick();
    check_val("sat_neg", int'(dac_o), -8192);
    set_zero_i = 1'b1;
    repeat (LAT + 2) tick();
    check_val("zero_dc", int'(dac_o), -1);
    repeat (100) tick();
    check_val("cont_busy", int'(busy_o), 1);

    // Soft reset wins over a simultaneous trigger.
    set_zero_i = 1'b0;
    set_amp_i = 14'h2000;
    set_dc_i = '0;
    set_rst_i = 1'b1;
    trig_i = 1'b1;
    tick();
    check_val("srst_busy_a", int'(busy_o), 0);
    check_val("srst_td_a", int'(trig_done_o), 0);
    tick();
    check_val("srst_busy_b", int'(busy_o), 0);
    check_val("srst_td_b", int'(trig_done_o), 0);
    set_rst_i = 1'b0;
    trig_i = 1'b0;
    repeat (LAT + 1) tick();
    check_val("srst_first", int'(dac_o), FIRST);

    // Hard reset in the middle of a run.
    buf_write(0, 0);
    set_size_i = 5'd16;
    burst(11);
    check_val("hrst_pre", dac_log[10], 400);
    rst = 1'b1;
    tick();
    check_val("hrst_dac", int'(dac_o), 0);
    check_val("hrst_busy", int'(busy_o), 0);
    check_val("hrst_rpnt", int'(rpnt_o), 0);
    rst = 1'b0;
    repeat (LAT + 1) tick();
    check_val("hrst_first", int'(dac_o), FIRST);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
